// File: rtl/id_ex_pipe_reg_if.sv
// rtl/id_ex_pipe_reg_if.sv - decode-to-execute pipeline register bundle
// Purpose: groups the hazard controls, the decode-stage word (D) and the
//          execute-stage word (E) of the ID/EX register into one bundle.
// Ports (modport master = decode/hazard side, slave = pipeline register):
//   stallE, flushE                      hazard unit controls
//   validD, control D fields, rd1D..pcPlus4D, rs1D/rs2D/rdD
//   validE, control E fields, rd1E..pcPlus4E, rs1E/rs2E/rdE
//   bubbleCount                         bubbles inserted since reset
interface id_ex_pipe_reg_if #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
);
    logic            stallE;
    logic            flushE;

    logic            validD;
    logic            regWriteD;
    logic            memWriteD;
    logic            ALUSrcD;
    logic            luiD;
    logic [1:0]      resultSrcD;
    logic [1:0]      jumpD;
    logic [2:0]      branchD;
    logic [2:0]      ALUControlD;
    logic [XLEN-1:0] rd1D;
    logic [XLEN-1:0] rd2D;
    logic [XLEN-1:0] immExtD;
    logic [XLEN-1:0] pcD;
    logic [XLEN-1:0] pcPlus4D;
    logic [4:0]      rs1D;
    logic [4:0]      rs2D;
    logic [4:0]      rdD;

    logic            validE;
    logic            regWriteE;
    logic            memWriteE;
    logic            ALUSrcE;
    logic            luiE;
    logic [1:0]      resultSrcE;
    logic [1:0]      jumpE;
    logic [2:0]      branchE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] rd1E;
    logic [XLEN-1:0] rd2E;
    logic [XLEN-1:0] immExtE;
    logic [XLEN-1:0] pcE;
    logic [XLEN-1:0] pcPlus4E;
    logic [4:0]      rs1E;
    logic [4:0]      rs2E;
    logic [4:0]      rdE;
    logic [CNTW-1:0] bubbleCount;

    modport master (
        output stallE, flushE,
        output validD, regWriteD, memWriteD, ALUSrcD, luiD, resultSrcD, jumpD,
               branchD, ALUControlD, rd1D, rd2D, immExtD, pcD, pcPlus4D,
               rs1D, rs2D, rdD,
        input  validE, regWriteE, memWriteE, ALUSrcE, luiE, resultSrcE, jumpE,
               branchE, ALUControlE, rd1E, rd2E, immExtE, pcE, pcPlus4E,
               rs1E, rs2E, rdE, bubbleCount
    );

    modport slave (
        input  stallE, flushE,
        input  validD, regWriteD, memWriteD, ALUSrcD, luiD, resultSrcD, jumpD,
               branchD, ALUControlD, rd1D, rd2D, immExtD, pcD, pcPlus4D,
               rs1D, rs2D, rdD,
        output validE, regWriteE, memWriteE, ALUSrcE, luiE, resultSrcE, jumpE,
               branchE, ALUControlE, rd1E, rd2E, immExtE, pcE, pcPlus4E,
               rs1E, rs2E, rdE, bubbleCount
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with stall, flush and bubble counter
// Purpose: registers the decode word for the execute stage. Priority per edge:
//          rst (clear all) > flushE (load all-zero bubble, count it) >
//          stallE (hold) > advance (copy D to E).
// Ports:
//   clk  core clock, rising edge
//   rst  synchronous active-high reset
//   bus  id_ex_pipe_reg_if.slave: D inputs, hazard controls, E outputs,
//        bubbleCount
module id_ex_pipe_reg #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input logic             clk,
    input logic             rst,
    id_ex_pipe_reg_if.slave bus
);
    typedef struct packed {
        logic            valid;
        logic            regWrite;
        logic            memWrite;
        logic            aluSrc;
        logic            lui;
        logic [1:0]      resultSrc;
        logic [1:0]      jump;
        logic [2:0]      branch;
        logic [2:0]      aluControl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] immExt;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcPlus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } ex_word_t;

    ex_word_t        word_in;
    ex_word_t        word_d;
    ex_word_t        word_q;
    logic [CNTW-1:0] count_d;
    logic [CNTW-1:0] count_q;

    // Reserved encodings travel through untouched; no decode checks here.
    assign word_in = '{
        valid:      bus.validD,
        regWrite:   bus.regWriteD,
        memWrite:   bus.memWriteD,
        aluSrc:     bus.ALUSrcD,
        lui:        bus.luiD,
        resultSrc:  bus.resultSrcD,
        jump:       bus.jumpD,
        branch:     bus.branchD,
        aluControl: bus.ALUControlD,
        rd1:        bus.rd1D,
        rd2:        bus.rd2D,
        immExt:     bus.immExtD,
        pc:         bus.pcD,
        pcPlus4:    bus.pcPlus4D,
        rs1:        bus.rs1D,
        rs2:        bus.rs2D,
        rd:         bus.rdD
    };

    always_comb begin
        word_d  = word_q;
        count_d = count_q;
        if (bus.flushE) begin
            // All-zero bubble: no register/memory write, no jump or branch.
            word_d  = '0;
            count_d = count_q + CNTW'(1);   // wraps modulo 2^CNTW
        end else if (!bus.stallE) begin
            word_d = word_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            count_q <= '0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    assign bus.validE      = word_q.valid;
    assign bus.regWriteE   = word_q.regWrite;
    assign bus.memWriteE   = word_q.memWrite;
    assign bus.ALUSrcE     = word_q.aluSrc;
    assign bus.luiE        = word_q.lui;
    assign bus.resultSrcE  = word_q.resultSrc;
    assign bus.jumpE       = word_q.jump;
    assign bus.branchE     = word_q.branch;
    assign bus.ALUControlE = word_q.aluControl;
    assign bus.rd1E        = word_q.rd1;
    assign bus.rd2E        = word_q.rd2;
    assign bus.immExtE     = word_q.immExt;
    assign bus.pcE         = word_q.pc;
    assign bus.pcPlus4E    = word_q.pcPlus4;
    assign bus.rs1E        = word_q.rs1;
    assign bus.rs2E        = word_q.rs2;
    assign bus.rdE         = word_q.rd;
    assign bus.bubbleCount = count_q;
endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Decode-to-execute pipeline register of the 5-stage RISC-V core. It captures the decode-stage control word from the main controller plus the register-file operands, immediate and PC values. It presents them to the execute stage one cycle later. It supports stall (hold), flush (bubble insertion) and a 16-bit bubble counter for performance debug.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNTW, 16, bubble counter width

Ports (clock and reset first):
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stallE  in  1  hold current contents (from hazard unit)
- flushE  in  1  replace next contents with a bubble (from hazard unit)
- validD  in  1  decode slot holds a real instruction
- regWriteD, memWriteD, ALUSrcD, luiD  in  1 each  controller outputs
- resultSrcD  in  2  result mux select
- jumpD  in  2  01 JAL, 10 JALR, 00 none
- branchD  in  3  001 BEQ, 010 BNE, 011 BLT, 100 BGE, 000 none
- ALUControlD  in  3  decoded ALU operation
- rd1D, rd2D, immExtD, pcD, pcPlus4D  in  XLEN each  operands and PC values
- rs1D, rs2D, rdD  in  5 each  register indices (forwarding and hazard use)
- Each of the above has a matching output with the suffix E, for example regWriteE or rd1E, with the same width. Outputs are registered.
- validE  out  1  execute slot holds a real instruction
- bubbleCount  out  CNTW  number of bubbles inserted since reset

## Operation
- Every register is updated on the rising edge of clk. There are no combinational paths from inputs to outputs.
- The next-state action is chosen by priority, highest first:
  1. rst=1: all E outputs, validE and bubbleCount are cleared to 0.
  2. flushE=1: the bubble is loaded and every E output and validE become 0. flushE wins over stallE when both are asserted.
  3. stallE=1: all E outputs and validE hold their values.
  4. Otherwise, each D input is copied into its E register, and validD is copied into validE.
- A bubble is exactly zero on every field. This yields regWriteE=0, memWriteE=0, jumpE=00 and branchE=000, so a bubble can never write state or redirect the PC.
- bubbleCount increments by 1 on every edge with rst=0 and flushE=1, including edges where stallE is also 1.
  - It wraps modulo 2^CNTW: 16'hFFFF followed by a flush gives 16'h0000.
  - It holds during stalls and normal advance.
- Reset or flush applied mid-stall discards the held instruction. It is not replayed.
- Reserved encodings are passed through unmodified, for example branchD values 101-111 or resultSrcD/jumpD value 11. This block does no decode checking.
- Inputs are sampled only at the clock edge. Glitches between edges have no effect.

## Timing
- Latency is 1 cycle: D inputs present before edge N appear on the E outputs after edge N.
- Throughput is one instruction per cycle when stallE=0 and flushE=0.
- stallE or flushE asserted before edge N affects the register contents loaded at edge N only. Neither signal has any lasting effect after it is deasserted.
- Reset values: every E output is 0, validE=0 and bubbleCount=0. These values are visible after the first edge with rst=1. Before that first reset edge the outputs are undefined.
- Sustained stall holds indefinitely. bubbleCount is unchanged during the stall.
- Back-to-back flushes each count separately: 3 consecutive flush cycles give bubbleCount +3.

## Test plan
- Reset: drive all inputs to 1s with rst=1 for one edge.
  - Required: all E outputs are 0, validE=0 and bubbleCount=0.
- Pass-through: load a LW word on the D inputs and clock one edge with stall and flush low.
  - Word: regWriteD=1, ALUSrcD=1, resultSrcD=01, rd1D=32'h0000_1000, immExtD=32'h10, rdD=5, validD=1.
  - Required: the identical values appear on the E outputs one edge later.
- Stall: with a JAL word held, drive new D values and assert stallE for 3 edges.
  - Held word: jumpE=01, resultSrcE=10, pcPlus4E=32'h24.
  - Required: the E outputs keep the JAL word during the stall.
  - Required: after stallE is deasserted, the new word appears at the next edge.
- Flush: with a BNE word on the D inputs (branchD=010, validD=1), assert flushE for one edge.
  - Required: branchE=000, regWriteE=0, memWriteE=0, validE=0 and bubbleCount=1.
- Flush and stall together: assert flushE=1 and stallE=1 on the same edge.
  - Required: a bubble is loaded, not a hold, and bubbleCount increments.
- Counter wrap: preload the counter by issuing 65535 flushes, then issue one more.
  - Required: bubbleCount goes 16'hFFFF then 16'h0000.
  - Then assert rst mid-stall. Required: everything is 0 after one edge.
